// File: rtl/ring_osc_cal_ctrl_pkg.sv
// Shared state encoding and default parameter values for the ring oscillator
// calibration sequencer and the ADPLL top level.
package ring_osc_cal_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StOscRst  = 3'd1,
        StSettle  = 3'd2,
        StMeasure = 3'd3,
        StEval    = 3'd4,
        StFail    = 3'd5
    } state_e;

    localparam int unsigned DefCtrlWidth    = 5;
    localparam int unsigned DefCntWidth     = 16;
    localparam int unsigned DefWindowCycles = 1024;
    localparam int unsigned DefSettleCycles = 16;
    localparam int unsigned DefResetCycles  = 4;
    localparam int unsigned DefMaxIter      = 64;
    localparam int unsigned DefInitCode     = 0;

endpackage

// File: rtl/ring_osc_cal_ctrl_freq_window_counter.sv
// Fixed-length measurement window: counts osc edge pulses over WINDOW_CYCLES
// reference cycles, starting with the cycle in which start is high.
module freq_window_counter
    import ring_osc_cal_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = DefCntWidth,
    parameter int unsigned WINDOW_CYCLES = DefWindowCycles
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 osc_edge,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int unsigned TimerW = $clog2(WINDOW_CYCLES);

    logic              running_q;
    logic [TimerW-1:0] timer_q;
    logic [CNT_WIDTH-1:0] count_q;

    // High during the last cycle of the window; count is final on the next cycle.
    assign done  = running_q && !start && (timer_q == TimerW'(WINDOW_CYCLES - 1));
    assign count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            timer_q   <= '0;
            count_q   <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            timer_q   <= TimerW'(1);
            count_q   <= {{(CNT_WIDTH - 1){1'b0}}, osc_edge};
        end else if (running_q) begin
            if (osc_edge && (count_q != {CNT_WIDTH{1'b1}})) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
            if (done) begin
                running_q <= 1'b0;
            end else begin
                timer_q <= timer_q + TimerW'(1);
            end
        end
    end

endmodule

// File: rtl/ring_osc_cal_ctrl.sv
// Closed-loop calibration/tracking sequencer for the ring oscillator: steps
// freq_sel until the measured edge count is within tolerance of the target.
module ring_osc_cal_ctrl
    import ring_osc_cal_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_WIDTH    = DefCtrlWidth,
    parameter int unsigned CNT_WIDTH     = DefCntWidth,
    parameter int unsigned WINDOW_CYCLES = DefWindowCycles,
    parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
    parameter int unsigned RESET_CYCLES  = DefResetCycles,
    parameter int unsigned MAX_ITER      = DefMaxIter,
    parameter int unsigned INIT_CODE     = DefInitCode
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [CNT_WIDTH-1:0]  target_i,
    input  logic [CNT_WIDTH-1:0]  tol_i,
    input  logic                  osc_edge_i,
    output logic                  osc_enable_o,
    output logic                  osc_reset_o,
    output logic [CTRL_WIDTH-1:0] freq_sel_o,
    output logic [CNT_WIDTH-1:0]  meas_count_o,
    output logic                  meas_valid_o,
    output logic                  locked_o,
    output logic                  fail_o,
    output logic                  busy_o
);

    localparam int unsigned TimerMax = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES
                                                                      : SETTLE_CYCLES;
    localparam int unsigned TimerW   = ($clog2(TimerMax) > 0) ? $clog2(TimerMax) : 1;
    localparam int unsigned IterW    = $clog2(MAX_ITER + 1);

    state_e                 state_q;
    logic [TimerW-1:0]      timer_q;
    logic [IterW-1:0]       iter_q;
    logic [IterW-1:0]       iter_inc;
    logic                   win_start_q;
    logic                   win_done;
    logic [CNT_WIDTH-1:0]   win_count;
    logic                   osc_enable_q, osc_reset_q, meas_valid_q, locked_q, fail_q, busy_q;
    logic [CTRL_WIDTH-1:0]  freq_sel_q;
    logic [CNT_WIDTH-1:0]   meas_count_q;

    logic signed [CNT_WIDTH:0] cmp_diff;
    logic [CNT_WIDTH:0]        abs_diff;
    logic                      in_tol, too_low, at_limit;

    freq_window_counter #(
        .CNT_WIDTH     (CNT_WIDTH),
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_window (
        .clk      (clk_i),
        .rst_n    (reset_n_i),
        .start    (win_start_q),
        .osc_edge (osc_edge_i),
        .done     (win_done),
        .count    (win_count)
    );

    always_comb begin
        cmp_diff = $signed({1'b0, win_count}) - $signed({1'b0, target_i});
        abs_diff = cmp_diff[CNT_WIDTH] ? $unsigned(-cmp_diff) : $unsigned(cmp_diff);
        in_tol   = abs_diff <= {1'b0, tol_i};
        too_low  = cmp_diff[CNT_WIDTH];
        at_limit = too_low ? (freq_sel_q == {CTRL_WIDTH{1'b1}}) : (freq_sel_q == '0);
        iter_inc = iter_q + IterW'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            iter_q       <= '0;
            win_start_q  <= 1'b0;
            osc_enable_q <= 1'b0;
            osc_reset_q  <= 1'b1;
            freq_sel_q   <= CTRL_WIDTH'(INIT_CODE);
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            win_start_q  <= 1'b0;
            if (stop_i) begin
                state_q      <= StIdle;
                osc_enable_q <= 1'b0;
                osc_reset_q  <= 1'b1;
                locked_q     <= 1'b0;
                fail_q       <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StFail: begin
                        if (start_i) begin
                            state_q      <= StOscRst;
                            timer_q      <= '0;
                            iter_q       <= '0;
                            freq_sel_q   <= CTRL_WIDTH'(INIT_CODE);
                            osc_enable_q <= 1'b0;
                            osc_reset_q  <= 1'b1;
                            locked_q     <= 1'b0;
                            fail_q       <= 1'b0;
                            busy_q       <= 1'b1;
                        end
                    end
                    StOscRst: begin
                        if (timer_q == TimerW'(RESET_CYCLES - 1)) begin
                            state_q      <= StSettle;
                            timer_q      <= '0;
                            osc_reset_q  <= 1'b0;
                            osc_enable_q <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TimerW'(1);
                        end
                    end
                    StSettle: begin
                        if (timer_q == TimerW'(SETTLE_CYCLES - 1)) begin
                            state_q     <= StMeasure;
                            win_start_q <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TimerW'(1);
                        end
                    end
                    StMeasure: begin
                        if (win_done) begin
                            state_q <= StEval;
                        end
                    end
                    StEval: begin
                        meas_count_q <= win_count;
                        meas_valid_q <= 1'b1;
                        if (in_tol) begin
                            // Tracking: re-measure at the same code without settling.
                            locked_q    <= 1'b1;
                            iter_q      <= '0;
                            state_q     <= StMeasure;
                            win_start_q <= 1'b1;
                        end else begin
                            locked_q <= 1'b0;
                            if (!at_limit) begin
                                freq_sel_q <= too_low ? freq_sel_q + CTRL_WIDTH'(1)
                                                      : freq_sel_q - CTRL_WIDTH'(1);
                                iter_q     <= iter_inc;
                                timer_q    <= '0;
                            end
                            if (at_limit || (iter_inc == IterW'(MAX_ITER))) begin
                                state_q      <= StFail;
                                fail_q       <= 1'b1;
                                busy_q       <= 1'b0;
                                osc_enable_q <= 1'b0;
                                osc_reset_q  <= 1'b1;
                            end else begin
                                state_q <= StSettle;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign osc_enable_o = osc_enable_q;
    assign osc_reset_o  = osc_reset_q;
    assign freq_sel_o   = freq_sel_q;
    assign meas_count_o = meas_count_q;
    assign meas_valid_o = meas_valid_q;
    assign locked_o     = locked_q;
    assign fail_o       = fail_q;
    assign busy_o       = busy_q;

endmodule
